// File: rtl/digit_demux.sv
// digit_demux: four 8-bit held registers loaded by one-hot addressed writes,
// a sequential four-cycle clear, and a free-running one-hot scan select.
// Optional macro DIGIT_DEMUX_BLANK_EN inserts a one-cycle all-zero gap on
// every scan step.
module digit_demux #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic [3:0]       dest,
    output logic             din_ready,
    input  logic             clr,
    output logic             err,
    output logic [7:0]       I0,
    output logic [7:0]       I1,
    output logic [7:0]       I2,
    output logic [7:0]       I3,
    output logic [3:0]       s
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR0,
        CLR1,
        CLR2,
        CLR3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             wr_acc;
    logic             wr_good;
    logic [CNT_W-1:0] cnt;
    logic             wrap;

    // Clear FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Clear FSM next state and write-ready; clr outside IDLE is ignored
    always_comb begin
        state_nxt = state;
        din_ready = 1'b0;
        case (state)
            IDLE: begin
                din_ready = !clr;
                if (clr) begin
                    state_nxt = CLR0;
                end
            end
            CLR0:    state_nxt = CLR1;
            CLR1:    state_nxt = CLR2;
            CLR2:    state_nxt = CLR3;
            CLR3:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_acc  = din_valid && din_ready;
    assign wr_good = wr_acc && $onehot(dest);

    // Held registers and error pulse; clears and writes never coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            I0  <= 8'h00;
            I1  <= 8'h00;
            I2  <= 8'h00;
            I3  <= 8'h00;
            err <= 1'b0;
        end else begin
            err <= wr_acc && !$onehot(dest);
            if (wr_good && dest[0]) I0 <= din;
            if (wr_good && dest[1]) I1 <= din;
            if (wr_good && dest[2]) I2 <= din;
            if (wr_good && dest[3]) I3 <= din;
            case (state)
                CLR0:    I0 <= 8'h00;
                CLR1:    I1 <= 8'h00;
                CLR2:    I2 <= 8'h00;
                CLR3:    I3 <= 8'h00;
                default: ;
            endcase
        end
    end

    assign wrap = (cnt == CNT_LAST);

`ifdef DIGIT_DEMUX_BLANK_EN
    logic       blank;
    logic [3:0] pos;

    // Scan with a one-cycle zero gap; the prescaler holds during the gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            s     <= 4'b0001;
            pos   <= 4'b0001;
            blank <= 1'b0;
        end else if (blank) begin
            blank <= 1'b0;
            s     <= pos;
        end else if (wrap) begin
            cnt   <= '0;
            blank <= 1'b1;
            s     <= 4'b0000;
            pos   <= {pos[2:0], pos[3]};
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`else
    // Scan prescaler; s rotates directly on each wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            s   <= 4'b0001;
        end else if (wrap) begin
            cnt <= '0;
            s   <= {s[2:0], s[3]};
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_digit_demux.sv
// Directed testbench for digit_demux (SCAN_DIV=3): table of write/clear
// vectors plus hand sequences for reset values, reset mid-clear and scan.
module tb_digit_demux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic [3:0] dest = 4'b0000;
    logic       clr = 1'b0;
    logic       din_ready;
    logic       err;
    logic [7:0] I0, I1, I2, I3;
    logic [3:0] s;

    int total = 0;
    int bad   = 0;

    digit_demux #(.SCAN_DIV(3), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .dest      (dest),
        .din_ready (din_ready),
        .clr       (clr),
        .err       (err),
        .I0        (I0),
        .I1        (I1),
        .I2        (I2),
        .I3        (I3),
        .s         (s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        vld;
        logic [7:0]  din;
        logic [3:0]  dest;
        logic        rdy;
        logic        err;
        logic [31:0] regs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic c, input logic v, input logic [7:0] d,
                       input logic [3:0] ds, input logic r, input logic e,
                       input logic [31:0] rg);
        vec_t x;
        x.clr = c; x.vld = v; x.din = d; x.dest = ds;
        x.rdy = r; x.err = e; x.regs = rg;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] scan_exp(input int k);
        int m;
`ifdef DIGIT_DEMUX_BLANK_EN
        if (k < 3) return 4'b0001;
        m = k - 3;
        if (m % 4 == 0) return 4'b0000;
        return 4'b0001 << ((1 + m / 4) % 4);
`else
        m = k / 3;
        return 4'b0001 << (m % 4);
`endif
    endfunction

    initial begin
        // regs expected after the edge, packed {I0,I1,I2,I3}
        add(0, 0, 8'h00, 4'b0000, 1, 0, 32'h00000000);
        add(0, 1, 8'hA5, 4'b0100, 1, 0, 32'h0000A500);
        add(0, 1, 8'h3C, 4'b0001, 1, 0, 32'h3C00A500);
        add(0, 1, 8'hFF, 4'b0110, 1, 1, 32'h3C00A500);
        add(0, 1, 8'hFF, 4'b0000, 1, 1, 32'h3C00A500);
        add(0, 0, 8'h00, 4'b0000, 1, 0, 32'h3C00A500);
        add(0, 1, 8'h11, 4'b0001, 1, 0, 32'h1100A500);
        add(0, 1, 8'h22, 4'b0010, 1, 0, 32'h1122A500);
        add(0, 1, 8'h33, 4'b0100, 1, 0, 32'h11223300);
        add(0, 1, 8'h44, 4'b1000, 1, 0, 32'h11223344);
        add(1, 1, 8'h99, 4'b1000, 0, 0, 32'h11223344);
        add(1, 1, 8'h99, 4'b1000, 0, 0, 32'h00223344);
        add(0, 1, 8'h99, 4'b1000, 0, 0, 32'h00003344);
        add(0, 1, 8'h99, 4'b1000, 0, 0, 32'h00000044);
        add(0, 1, 8'h99, 4'b1000, 0, 0, 32'h00000000);
        add(0, 0, 8'h00, 4'b0000, 1, 0, 32'h00000000);
        add(0, 1, 8'h5A, 4'b1000, 1, 0, 32'h0000005A);
        add(0, 1, 8'h77, 4'b0001, 1, 0, 32'h7700005A);

        // Reset values
        #12;
        chk("rst_regs", {I0, I1, I2, I3}, 32'h0);
        chk("rst_s", 32'(s), 32'h1);
        chk("rst_err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_ready", 32'(din_ready), 32'h1);

        // Vector table: ready before the edge, regs and err after it
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            clr = vecs[i].clr; din_valid = vecs[i].vld;
            din = vecs[i].din; dest = vecs[i].dest;
            #1 chk($sformatf("v%0d_ready", i), 32'(din_ready), 32'(vecs[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_regs", i), {I0, I1, I2, I3}, vecs[i].regs);
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
        end

        // Reset asserted while the clear sequence is in CLR1
        @(negedge clk);
        clr = 1'b1; din_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("mid_clr_i0", 32'(I0), 32'h0);
        chk("mid_clr_i3", 32'(I3), 32'h5A);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_regs", {I0, I1, I2, I3}, 32'h0);
        chk("mid_rst_s", 32'(s), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_rel_ready", 32'(din_ready), 32'h1);
        chk("scan_k0", 32'(s), 32'h1);

        // Scan sequence from release; ready must stay high (FSM idle)
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("scan_k%0d", k), 32'(s), 32'(scan_exp(k)));
            if (k <= 4) chk($sformatf("post_rst_ready%0d", k), 32'(din_ready), 32'h1);
        end
        chk("post_rst_regs", {I0, I1, I2, I3}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_demux.md
DIGIT_DEMUX -- requirements
Module: digit_demux

Interface
REQ-001 Parameter SCAN_DIV, default 1000, is the number of clk cycles each one-hot scan position is held; legal range 1..65535.
REQ-002 Parameter CNT_W, default 16, is the width of the scan prescaler counter; SCAN_DIV-1 SHALL fit in CNT_W bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 din  input  8  write data.
REQ-006 din_valid  input  1  write request qualifier.
REQ-007 dest  input  4  one-hot destination; bit k selects register Ik.
REQ-008 din_ready  output  1  block can accept a write this cycle.
REQ-009 clr  input  1  single-cycle request to clear all four registers.
REQ-010 err  output  1  one-cycle pulse flagging a rejected write.
REQ-011 I0, I1, I2, I3  output  8 each  held register values, sized to feed the one-hot 4:1 selector directly.
REQ-012 s  output  4  one-hot scan select paired with I0..I3.

Function
REQ-013 Write handshake: a write is accepted in any cycle where din_valid=1 and din_ready=1.
REQ-014 din_ready SHALL be combinational: 0 while a clear sequence is active or clr=1, otherwise 1.
REQ-015 Accepted write with dest exactly one-hot: the selected Ik loads din at that edge and is visible the next cycle (1-cycle latency); other registers are unchanged.
REQ-016 Accepted write with dest not one-hot (0000 or two or more bits set): no register changes, and err=1 for exactly the next cycle.
REQ-017 err SHALL be 0 in every other cycle; back-to-back bad writes give back-to-back err pulses.
REQ-018 Clear sequence: clr=1 while idle starts a 4-cycle sequence that zeroes I0, I1, I2, I3 in that order, one register per cycle.
REQ-019 The clear state machine has states IDLE, CLR0, CLR1, CLR2 and CLR3, and advances IDLE->CLR0->CLR1->CLR2->CLR3->IDLE; in CLRk, Ik is zeroed.
REQ-020 clr=1 and din_valid=1 in the same cycle: the clear wins and the write is not accepted (din_ready=0).
REQ-021 clr asserted during an active clear sequence is ignored; the sequence is not restarted.
REQ-022 Scan prescaler counter: counts 0..SCAN_DIV-1 and wraps to 0; on the wrap edge, s advances one position.
REQ-023 Scan order: 0001->0010->0100->1000->0001, wrapping continuously; scanning is independent of writes and clears.
REQ-024 SCAN_DIV=1: s advances every cycle.
REQ-025 Exactly one bit of s SHALL be set at all times, except as allowed by REQ-030.

Reset
REQ-026 While rst_n=0: I0..I3=8'h00, s=4'b0001, err=0, clear FSM=IDLE, prescaler counter=0.
REQ-027 Reset asserted mid-clear or mid-write SHALL abort the operation immediately, with no partial effects after release.
REQ-028 First rising clk edge after rst_n goes high: din_ready=1, and the counter begins from 0.

Configuration
REQ-029 Macro DIGIT_DEMUX_BLANK_EN selects optional scan blanking.
REQ-030 With DIGIT_DEMUX_BLANK_EN defined: on each prescaler wrap, s=4'b0000 for exactly one cycle, then the next one-hot value; each position then lasts SCAN_DIV cycles and each blank gap 1 cycle.
REQ-031 Without DIGIT_DEMUX_BLANK_EN: s goes directly to the next one-hot value on the wrap edge, with no zero cycle.

Verification
REQ-032 Reset: rst_n=0 then release -> I0..I3=00, s=0001, err=0, din_ready=1.
REQ-033 Writes: din=8'hA5 with dest=0100, then din=8'h3C with dest=0001 -> I2=A5 one cycle after the first, then I0=3C; I1 and I3 stay 00.
REQ-034 Bad dest: din=8'hFF with dest=0110, then dest=0000 -> no register changes; err high for the two consecutive cycles following the requests.
REQ-035 Clear collision: I0..I3 preloaded 11/22/33/44; clr=1 and din_valid=1 with dest=1000 in the same cycle -> din_ready=0 for 5 cycles; registers zero in order I0..I3; I3 ends 00.
REQ-036 Scan with SCAN_DIV=3: s steps 0001, 0010, 0100, 1000, 0001 every 3 cycles; with DIGIT_DEMUX_BLANK_EN defined, one 0000 cycle precedes each step.
REQ-037 Reset mid-clear: rst_n pulsed low in CLR1 -> all registers 00, FSM IDLE, din_ready=1 after release.
